// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel switch debouncer driven by a shared sample tick.
//   clk      system clock, rising edge
//   rst_a    asynchronous active-low reset
//   en       enable; low freezes the tick counter and all channel state
//   btn_in   raw asynchronous inputs, one bit per channel
//   btn_db   debounced level per channel
//   btn_rise one-cycle pulse when a btn_db bit goes 0->1
//   btn_fall one-cycle pulse when a btn_db bit goes 1->0
//   tick     registered sample strobe, one cycle wide
module debounce_bank #(
   parameter int N_CH       = 4,
   parameter int TICK_MAX   = 500000,
   parameter int STABLE_CNT = 4
) (
   input  logic            clk,
   input  logic            rst_a,
   input  logic            en,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_db,
   output logic [N_CH-1:0] btn_rise,
   output logic [N_CH-1:0] btn_fall,
   output logic            tick
);
   localparam int TW = (TICK_MAX < 1) ? 1 : $clog2(TICK_MAX + 1);
   localparam int SW = (STABLE_CNT < 1) ? 1 : $clog2(STABLE_CNT + 1);
   typedef enum logic {STABLE, CHANGING} state_t;
   logic [TW-1:0]   tick_cnt;
   logic [N_CH-1:0] meta, sync;
   logic [N_CH-1:0] db_nx, rise_nx, fall_nx;
   logic [SW-1:0]   cnt [N_CH];
   logic [SW-1:0]   cnt_nx [N_CH];
   state_t          state [N_CH];
   state_t          state_nx [N_CH];
   logic            upd;
   logic            wrap;
   assign wrap = tick_cnt >= TW'(TICK_MAX);
   assign upd  = tick & en;
   always_ff @(posedge clk or negedge rst_a)
      if (!rst_a) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
      end else if (en) begin
         tick     <= wrap;
         tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
      end else
         tick <= 1'b0;
   always_ff @(posedge clk or negedge rst_a)
      if (!rst_a) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= btn_in;
         sync <= meta;
      end
   // cnt counts consecutive sample ticks on which sync disagreed with btn_db;
   // the disagreement is accepted on the STABLE_CNT-th such tick.
   always_comb begin
      db_nx   = btn_db;
      rise_nx = '0;
      fall_nx = '0;
      for (int i = 0; i < N_CH; i++) begin
         state_nx[i] = state[i];
         cnt_nx[i]   = cnt[i];
         if (upd) begin
            if (sync[i] == btn_db[i]) begin
               cnt_nx[i]   = '0;
               state_nx[i] = STABLE;
            end else if (cnt[i] != SW'(STABLE_CNT - 1)) begin
               cnt_nx[i]   = cnt[i] + 1'b1;
               state_nx[i] = CHANGING;
            end else begin
               db_nx[i]    = sync[i];
               rise_nx[i]  = sync[i];
               fall_nx[i]  = ~sync[i];
               cnt_nx[i]   = '0;
               state_nx[i] = STABLE;
            end
         end
      end
   end
   always_ff @(posedge clk or negedge rst_a)
      if (!rst_a) begin
         btn_db   <= '0;
         btn_rise <= '0;
         btn_fall <= '0;
         for (int i = 0; i < N_CH; i++) begin
            cnt[i]   <= '0;
            state[i] <= STABLE;
         end
      end else begin
         btn_db   <= db_nx;
         btn_rise <= rise_nx;
         btn_fall <= fall_nx;
         cnt      <= cnt_nx;
         state    <= state_nx;
      end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: randomized and directed checks of debounce_bank against a behavioural model.
module tb_debounce_bank;
   localparam int N_CH = 2, TICK_MAX = 3, STABLE_CNT = 3;
   logic       clk = 1'b0, rst_a = 1'b1, en = 1'b1;
   logic [1:0] btn_in = 2'b00, btn_db, btn_rise, btn_fall;
   logic       tick;
   int         total = 0, bad = 0;
   debounce_bank #(.N_CH(N_CH), .TICK_MAX(TICK_MAX), .STABLE_CNT(STABLE_CNT)) dut (
      .clk(clk), .rst_a(rst_a), .en(en), .btn_in(btn_in),
      .btn_db(btn_db), .btn_rise(btn_rise), .btn_fall(btn_fall), .tick(tick)
   );
   always #5 clk = ~clk;
   // Model: tick phase from the number of enabled edges since reset, a
   // two-edge input delay, and a per-channel run length of disagreeing samples.
   int         en_cycles;
   int         run [2];
   bit         m_tick;
   bit   [1:0] pipe1, pipe2, m_db, m_rise, m_fall;
   always @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         en_cycles <= 0; m_tick <= 0; pipe1 <= 0; pipe2 <= 0;
         m_db <= 0; m_rise <= 0; m_fall <= 0;
         for (int c = 0; c < 2; c++) run[c] <= 0;
      end else begin
         m_rise <= 0;
         m_fall <= 0;
         if (en && m_tick)
            for (int c = 0; c < 2; c++)
               if (pipe2[c] == m_db[c]) run[c] <= 0;
               else if (run[c] + 1 == STABLE_CNT) begin
                  run[c] <= 0; m_db[c] <= pipe2[c];
                  m_rise[c] <= pipe2[c]; m_fall[c] <= ~pipe2[c];
               end else run[c] <= run[c] + 1;
         pipe1 <= btn_in;
         pipe2 <= pipe1;
         m_tick <= en && ((en_cycles + 1) % (TICK_MAX + 1) == 0);
         if (en) en_cycles <= en_cycles + 1;
      end
   end
   task automatic test_reset();
      #1 rst_a = 1'b0;
      #20;
      total++;
      if ({btn_db, btn_rise, btn_fall, tick} !== 7'b0) begin
         bad++; $display("FAIL reset_hold: got %b want 0000000", {btn_db, btn_rise, btn_fall, tick});
      end
      @(negedge clk) rst_a = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         @(negedge clk);
         total++;
         if (tick !== (e % 4 == 0)) begin
            bad++; $display("FAIL reset_tick edge%0d: got %b want %b", e, tick, e % 4 == 0);
         end
         total++;
         if ({btn_db, btn_rise, btn_fall} !== 6'b0) begin
            bad++; $display("FAIL reset_idle edge%0d: got %b want 000000", e, {btn_db, btn_rise, btn_fall});
         end
      end
   endtask
   task automatic test_press();
      int rises = 0;
      btn_in = 2'b01;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         total++;
         if ({btn_db, btn_rise, btn_fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
            bad++; $display("FAIL press: got %b want %b", {btn_db, btn_rise, btn_fall, tick}, {m_db, m_rise, m_fall, m_tick});
         end
         if (btn_rise[0]) rises++;
      end
      total++;
      if (rises != 1) begin bad++; $display("FAIL press_rises: got %0d want 1", rises); end
      total++;
      if (btn_db !== 2'b01) begin bad++; $display("FAIL press_db: got %b want 01", btn_db); end
   endtask
   task automatic test_glitch();
      btn_in = 2'b00;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         total++;
         if ({btn_db, btn_rise, btn_fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
            bad++; $display("FAIL release: got %b want %b", {btn_db, btn_rise, btn_fall, tick}, {m_db, m_rise, m_fall, m_tick});
         end
      end
      btn_in = 2'b01;
      for (int k = 0; k < 38; k++) begin
         @(negedge clk);
         if (k == 7) btn_in = 2'b00;
         total++;
         if ({btn_db, btn_rise, btn_fall} !== 6'b0) begin
            bad++; $display("FAIL glitch: got %b want 000000", {btn_db, btn_rise, btn_fall});
         end
         total++;
         if (tick !== m_tick) begin bad++; $display("FAIL glitch_tick: got %b want %b", tick, m_tick); end
      end
   endtask
   task automatic test_both_fall();
      int both = 0, split = 0;
      btn_in = 2'b11;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         total++;
         if ({btn_db, btn_rise, btn_fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
            bad++; $display("FAIL both_rise: got %b want %b", {btn_db, btn_rise, btn_fall, tick}, {m_db, m_rise, m_fall, m_tick});
         end
      end
      total++;
      if (btn_db !== 2'b11) begin bad++; $display("FAIL both_high: got %b want 11", btn_db); end
      btn_in = 2'b00;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (btn_fall == 2'b11) both++;
         if (btn_fall == 2'b01 || btn_fall == 2'b10) split++;
         total++;
         if ({btn_db, btn_rise, btn_fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
            bad++; $display("FAIL both_fall: got %b want %b", {btn_db, btn_rise, btn_fall, tick}, {m_db, m_rise, m_fall, m_tick});
         end
      end
      total++;
      if (both != 1 || split != 0) begin bad++; $display("FAIL both_pulse: got both=%0d split=%0d want 1 0", both, split); end
      total++;
      if (btn_db !== 2'b00) begin bad++; $display("FAIL both_low: got %b want 00", btn_db); end
   endtask
   task automatic test_enable();
      bit [1:0] held;
      int       first = 0;
      for (int k = 0; k < 8 && !m_tick; k++) @(negedge clk);
      total++;
      if (tick !== 1'b1) begin bad++; $display("FAIL en_align: got %b want 1", tick); end
      @(negedge clk);
      en = 1'b0;
      held = m_db;
      btn_in = ~m_db;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         total++;
         if (tick !== 1'b0 || btn_db !== held) begin
            bad++; $display("FAIL en_freeze: got tick=%b db=%b want 0 %b", tick, btn_db, held);
         end
      end
      en = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (tick && first == 0) first = k;
         total++;
         if ({btn_db, btn_rise, btn_fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
            bad++; $display("FAIL en_resume: got %b want %b", {btn_db, btn_rise, btn_fall, tick}, {m_db, m_rise, m_fall, m_tick});
         end
      end
      total++;
      if (first != 3) begin bad++; $display("FAIL en_first_tick: got %0d want 3", first); end
   endtask
   task automatic test_reset_mid();
      int ticks = 0, rise_at = 0;
      btn_in = 2'b00;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         total++;
         if ({btn_db, btn_rise, btn_fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
            bad++; $display("FAIL rmid_idle: got %b want %b", {btn_db, btn_rise, btn_fall, tick}, {m_db, m_rise, m_fall, m_tick});
         end
      end
      btn_in = 2'b01;
      for (int k = 0; k < 30 && run[0] < 2; k++) @(negedge clk);
      total++;
      if (run[0] < 1) begin bad++; $display("FAIL rmid_changing: got run=%0d want >=1", run[0]); end
      @(negedge clk);
      #2 rst_a = 1'b0;
      #1;
      total++;
      if ({btn_db, btn_rise, btn_fall, tick} !== 7'b0) begin
         bad++; $display("FAIL rmid_async: got %b want 0000000", {btn_db, btn_rise, btn_fall, tick});
      end
      @(negedge clk) rst_a = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (btn_rise[0] && rise_at == 0) rise_at = k;
         if (tick && rise_at == 0) ticks++;
         total++;
         if ({btn_db, btn_rise, btn_fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
            bad++; $display("FAIL rmid_after: got %b want %b", {btn_db, btn_rise, btn_fall, tick}, {m_db, m_rise, m_fall, m_tick});
         end
      end
      total++;
      if (rise_at != 13 || ticks != 3) begin
         bad++; $display("FAIL rmid_latency: got edge=%0d ticks=%0d want 13 3", rise_at, ticks);
      end
   endtask
   task automatic test_random();
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         total++;
         if ({btn_db, btn_rise, btn_fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
            bad++; $display("FAIL random cyc%0d: got %b want %b", k, {btn_db, btn_rise, btn_fall, tick}, {m_db, m_rise, m_fall, m_tick});
         end
         total++;
         if ((btn_rise & btn_fall) !== 2'b00) begin bad++; $display("FAIL random_excl: got %b want 00", btn_rise & btn_fall); end
         if ($urandom_range(0, 11) == 0) btn_in = 2'($urandom_range(0, 3));
         en = $urandom_range(0, 7) != 0;
      end
      en = 1'b1;
   endtask
   initial begin
      test_reset();
      test_press();
      test_glitch();
      test_both_fall();
      test_enable();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
